// File: rtl/uart_tx_piso.sv
// UART transmit path: frames a parallel byte as start, LSB-first data, optional parity and stop,
// paced by an external baud tick, with a one-entry holding register for back-to-back frames.
module uart_tx_piso #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    input  logic                  tick,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  ready,
    output logic                  tx_done,
    output logic                  overrun
);
    localparam int   CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam logic PAR_ON  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  par_q, par_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic                  stop_tick;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] b);
        return (^b) ^ PAR_ODD;
    endfunction

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        stop_tick   = (state_q == S_STOP) && tick;

        // The stop-tick cycle owns the holding register itself (handover below).
        if (load && (state_q != S_IDLE) && !stop_tick) begin
            if (!hold_full_q) begin
                hold_d      = data_in;
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    shift_d = data_in;
                    par_d   = parity_of(data_in);
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q < CNT_W'(DATA_WIDTH)) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (PAR_ON) begin
                        tx_d    = par_q;
                        state_d = S_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    done_d = 1'b1;
                    if (hold_full_q) begin
                        shift_d = hold_q;
                        par_d   = parity_of(hold_q);
                        tx_d    = 1'b0;
                        state_d = S_START;
                        if (load) begin
                            hold_d = data_in;
                        end else begin
                            hold_full_d = 1'b0;
                        end
                    end else if (load) begin
                        shift_d = data_in;
                        par_d   = parity_of(data_in);
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ready_d = !hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx_out  = tx_q;
    assign busy    = busy_q;
    assign ready   = ready_q;
    assign tx_done = done_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_uart_tx_piso.sv
// Bench for uart_tx_piso: three parity variants share one stimulus stream and are compared every
// cycle against a frame-position model; literal line sequences pin the model to known frames.
module tb_uart_tx_piso;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx[3], busy[3], ready[3], done[3], ovr[3];

    always #5 clk = ~clk;

    uart_tx_piso #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .tick(tick),
        .tx_out(tx[0]), .busy(busy[0]), .ready(ready[0]), .tx_done(done[0]), .overrun(ovr[0]));
    uart_tx_piso #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .tick(tick),
        .tx_out(tx[1]), .busy(busy[1]), .ready(ready[1]), .tx_done(done[1]), .overrun(ovr[1]));
    uart_tx_piso #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .tick(tick),
        .tx_out(tx[2]), .busy(busy[2]), .ready(ready[2]), .tx_done(done[2]), .overrun(ovr[2]));

    int n_checks = 0;
    int n_pass   = 0;
    int n_shown  = 0;

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else if (n_shown < 40) begin
            n_shown++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic timeout_fail(string name);
        n_checks++;
        $display("FAIL %s t=%0t actual=timeout required=completion", name, $time);
    endtask

    // ---------------- behavioural model: frame as a bit list, position index ----------------
    function automatic bit has_par(int k);
        return k != 0;
    endfunction

    function automatic int frame_len(int k);
        return has_par(k) ? 11 : 10;
    endfunction

    function automatic logic fbit(int k, logic [7:0] b, int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == frame_len(k) - 1) return 1'b1;
        return (^b) ^ (k == 2);
    endfunction

    bit         m_valid = 1'b0;
    bit         m_idle[3], m_armed[3], m_hf[3], m_ovr[3], m_done[3];
    int         m_idx[3];
    logic [7:0] m_cur[3], m_hold[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            automatic bit         idle = m_idle[k], armed = m_armed[k], hf = m_hf[k], ov = m_ovr[k];
            automatic bit         dn = 1'b0, stop_tick;
            automatic int         idx = m_idx[k];
            automatic logic [7:0] cur = m_cur[k], hold = m_hold[k];
            if (!reset) begin
                idle = 1'b1; armed = 1'b0; idx = 0; hf = 1'b0; ov = 1'b0;
            end else begin
                stop_tick = !idle && !armed && (idx == frame_len(k) - 1) && tick;
                dn = stop_tick;
                if (idle) begin
                    if (load) begin
                        cur = data_in; idle = 1'b0; armed = 1'b1;
                    end
                end else if (stop_tick) begin
                    if (hf) begin
                        cur = hold; idx = 0;
                        if (load) hold = data_in;
                        else hf = 1'b0;
                    end else if (load) begin
                        cur = data_in; idx = 0;
                    end else begin
                        idle = 1'b1;
                    end
                end else begin
                    if (load) begin
                        if (!hf) begin
                            hold = data_in; hf = 1'b1;
                        end else begin
                            ov = 1'b1;
                        end
                    end
                    if (tick) begin
                        if (armed) begin
                            armed = 1'b0; idx = 0;
                        end else begin
                            idx = idx + 1;
                        end
                    end
                end
            end
            m_idle[k]  <= idle;
            m_armed[k] <= armed;
            m_idx[k]   <= idx;
            m_cur[k]   <= cur;
            m_hold[k]  <= hold;
            m_hf[k]    <= hf;
            m_ovr[k]   <= ov;
            m_done[k]  <= dn;
        end
        if (!reset) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 3; k++) begin
                chk("tx_out", k, 32'(tx[k]),
                    32'((m_idle[k] || m_armed[k]) ? 1'b1 : fbit(k, m_cur[k], m_idx[k])));
                chk("busy", k, 32'(busy[k]), 32'(!m_idle[k]));
                chk("ready", k, 32'(ready[k]), 32'(!m_hf[k]));
                chk("tx_done", k, 32'(done[k]), 32'(m_done[k]));
                chk("overrun", k, 32'(ovr[k]), 32'(m_ovr[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    int   tick_per = 16;
    int   tick_cnt = 0;
    bit   tick_en  = 1'b1;
    int   done_cnt0 = 0;
    logic lg0[$], lg1[$], lg2[$];

    // One clock: logs the line after every tick taken while a frame was in progress.
    task automatic cyc();
        logic t;
        logic b0, b1, b2;
        t = tick; b0 = busy[0]; b1 = busy[1]; b2 = busy[2];
        @(posedge clk);
        #1;
        if (t && b0) lg0.push_back(tx[0]);
        if (t && b1) lg1.push_back(tx[1]);
        if (t && b2) lg2.push_back(tx[2]);
        if (done[0] === 1'b1) done_cnt0++;
        load = 1'b0;
        if (tick_en && tick_cnt >= tick_per - 1) begin
            tick = 1'b1;
            tick_cnt = 0;
        end else begin
            tick = 1'b0;
            if (tick_en) tick_cnt++;
        end
    endtask

    task automatic do_reset(int n);
        reset = 1'b0;
        repeat (n) cyc();
        reset = 1'b1;
    endtask

    task automatic send(logic [7:0] b);
        data_in = b;
        load = 1'b1;
        cyc();
    endtask

    task automatic wait_idle(string name, int maxc);
        int c = 0;
        while ((busy[0] | busy[1] | busy[2]) !== 1'b0 && c < maxc) begin
            cyc();
            c++;
        end
        if (c >= maxc) timeout_fail(name);
    endtask

    task automatic clear_logs();
        lg0.delete(); lg1.delete(); lg2.delete();
        done_cnt0 = 0;
    endtask

    task automatic chk_seq(string name, int k, logic q[$], logic [31:0] e, int n);
        logic [31:0] v = '0;
        chk({name, "_len"}, k, 32'(q.size() >= n), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i < q.size()) v[n-1-i] = q[i];
        end
        chk(name, k, v, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        do_reset(3);
        chk("rst_tx", 0, 32'(tx[0]), 32'd1);
        chk("rst_busy", 0, 32'(busy[0]), 32'd0);
        chk("rst_ready", 0, 32'(ready[0]), 32'd1);
        chk("rst_ovr", 0, 32'(ovr[0]), 32'd0);

        // Single frame, all three parity variants.
        clear_logs();
        send(8'hA5);
        wait_idle("a5_idle", 800);
        chk_seq("a5_line", 0, lg0, 32'b0101001011, 10);
        chk("a5_par_even", 1, 32'(lg1.size() > 9 ? lg1[9] : 1'bx), 32'd0);
        chk("a5_par_odd", 2, 32'(lg2.size() > 9 ? lg2[9] : 1'bx), 32'd1);
        chk("a5_done_cnt", 0, 32'(done_cnt0), 32'd1);
        chk("a5_idle_tx", 0, 32'(tx[0]), 32'd1);

        clear_logs();
        send(8'h01);
        wait_idle("01_idle", 800);
        chk("01_par_even", 1, 32'(lg1.size() > 9 ? lg1[9] : 1'bx), 32'd1);
        chk("01_par_odd", 2, 32'(lg2.size() > 9 ? lg2[9] : 1'bx), 32'd0);

        // Back-to-back through the holding register.
        clear_logs();
        send(8'h55);
        repeat (40) cyc();
        send(8'h0F);
        chk("b2b_ready", 0, 32'(ready[0]), 32'd0);
        wait_idle("b2b_idle", 1500);
        chk_seq("b2b_line", 0, lg0, 32'b0101010101_0111100001, 20);
        chk("b2b_done_cnt", 0, 32'(done_cnt0), 32'd2);

        // Overrun: third byte dropped.
        clear_logs();
        send(8'h11);
        repeat (20) cyc();
        send(8'h22);
        send(8'h33);
        chk("ovr_set", 0, 32'(ovr[0]), 32'd1);
        wait_idle("ovr_idle", 1500);
        chk_seq("ovr_line", 0, lg0, 32'b0100010001_0010001001, 20);
        chk("ovr_sticky", 0, 32'(ovr[0]), 32'd1);
        chk("ovr_frames", 0, 32'(done_cnt0), 32'd2);

        // Reset in the middle of the data bits.
        clear_logs();
        send(8'hFF);
        c = 0;
        while (lg0.size() < 6 && c < 500) begin
            cyc();
            c++;
        end
        if (c >= 500) timeout_fail("mid_reset_wait");
        repeat (3) cyc();
        do_reset(1);
        chk("mr_tx", 0, 32'(tx[0]), 32'd1);
        chk("mr_busy", 0, 32'(busy[0]), 32'd0);
        chk("mr_ready", 0, 32'(ready[0]), 32'd1);
        chk("mr_ovr", 0, 32'(ovr[0]), 32'd0);
        clear_logs();
        send(8'h3C);
        wait_idle("3c_idle", 800);
        chk_seq("3c_line", 0, lg0, 32'b0001111001, 10);

        // Armed without ticks: line holds idle level.
        clear_logs();
        tick_en = 1'b0;
        tick = 1'b0;
        send(8'h5A);
        repeat (100) cyc();
        chk("armed_tx", 0, 32'(tx[0]), 32'd1);
        chk("armed_busy", 0, 32'(busy[0]), 32'd1);
        tick_en = 1'b1;
        tick_cnt = 0;
        wait_idle("5a_idle", 800);
        chk_seq("5a_line", 0, lg0, 32'b0010110101, 10);

        // Randomised traffic, tick rates and occasional resets.
        for (int i = 0; i < 20000; i++) begin
            if (i % 1000 == 0) tick_per = $urandom_range(1, 8);
            if ($urandom_range(0, 29) == 0) begin
                data_in = 8'($urandom);
                load = 1'b1;
            end
            reset = ($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1;
            cyc();
        end
        reset = 1'b1;
        wait_idle("rand_idle", 2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
